// File: rtl/uc_arbiter_rr.sv
// Round-robin unit-clause arbiter: memory preload, N engine channels,
// per-variable polarity table, literal FIFO. Define UCARB_STATS_EN for counters.
module uc_arbiter_rr #(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = 8,
    parameter int NUM_VARS   = 64,
    parameter int Q_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        mem_valid,
    input  logic [LIT_W-1:0]            mem_lit,
    input  logic                        mem_done,
    output logic                        mem_ready,
    input  logic [NUM_ENGINE-1:0]       eng_valid,
    input  logic [NUM_ENGINE*LIT_W-1:0] eng_lit,
    output logic [NUM_ENGINE-1:0]       eng_ready,
    input  logic                        down_full,
    output logic                        out_valid,
    output logic [LIT_W-1:0]            out_lit,
    output logic [$clog2(Q_DEPTH):0]    q_count,
    output logic                        conflict,
    output logic [LIT_W-1:0]            conflict_lit,
    output logic [15:0]                 stat_pushed,
    output logic [15:0]                 stat_dropped
);

    localparam int PW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam int AW = $clog2(Q_DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = $clog2(NUM_VARS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CONF = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [LIT_W-1:0]    fifo_q [Q_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [NUM_VARS-1:0] pos_q, pos_d;
    logic [NUM_VARS-1:0] neg_q, neg_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic                conflict_q, conflict_d;
    logic [LIT_W-1:0]    conf_lit_q, conf_lit_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             mem_acc;
    logic             arb_en;
    logic [PW-1:0]    cand [NUM_ENGINE];
    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [LIT_W-1:0] sel_lit;
    logic             in_vld;
    logic [LIT_W-1:0] in_lit;
    logic             in_neg;
    logic [LIT_W-1:0] mag;
    logic             in_range;
    logic [VW-1:0]    vidx;
    logic             hit_same;
    logic             hit_opp;
    logic             do_push;
    logic             do_drop;
    logic             do_conf;
    logic             pop;

    assign fifo_full  = (count_q == CW'(Q_DEPTH));
    assign fifo_empty = (count_q == '0);

    assign mem_acc = (state_q == S_IDLE) & mem_valid & ~fifo_full & ~clear;
    assign arb_en  = (state_q == S_RUN) & ~fifo_full & ~clear;

    // Candidate channels in priority order, starting after the last grant.
    always_comb begin
        for (int k = 0; k < NUM_ENGINE; k++) begin
            cand[k] = PW'((int'(rr_q) + k) % NUM_ENGINE);
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (arb_en) begin
            for (int k = 0; k < NUM_ENGINE; k++) begin
                if (!gnt_any && eng_valid[cand[k]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[k];
                end
            end
        end
    end

    always_comb begin
        eng_ready = '0;
        sel_lit   = '0;
        for (int j = 0; j < NUM_ENGINE; j++) begin
            if (gnt_any && gnt_idx == PW'(j)) begin
                eng_ready[j] = 1'b1;
                sel_lit      = eng_lit[j*LIT_W +: LIT_W];
            end
        end
    end

    assign mem_ready = mem_acc;

    assign in_vld = mem_acc | gnt_any;
    assign in_lit = mem_acc ? mem_lit : sel_lit;
    assign in_neg = in_lit[LIT_W-1];
    assign mag    = in_neg ? (~in_lit + 1'b1) : in_lit;
    assign vidx   = VW'(mag);

    // The most-negative literal has no positive twin, so it is never a variable.
    always_comb begin
        in_range = 1'b1;
        if (in_lit == {1'b1, {(LIT_W-1){1'b0}}}) begin
            in_range = 1'b0;
        end else if (mag == '0) begin
            in_range = 1'b0;
        end else if (32'(mag) >= NUM_VARS) begin
            in_range = 1'b0;
        end
    end

    assign hit_same = in_neg ? neg_q[vidx] : pos_q[vidx];
    assign hit_opp  = in_neg ? pos_q[vidx] : neg_q[vidx];

    assign do_drop = in_vld & (~in_range | hit_same);
    assign do_conf = in_vld & in_range & ~hit_same & hit_opp;
    assign do_push = in_vld & in_range & ~hit_same & ~hit_opp;

    assign out_valid = ~fifo_empty & ~down_full & (state_q != S_CONF) & ~clear;
    assign pop       = out_valid;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pos_d      = pos_q;
        neg_d      = neg_q;
        rr_d       = rr_q;
        conflict_d = conflict_q;
        conf_lit_d = conf_lit_q;
        if (clear) begin
            state_d    = S_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pos_d      = '0;
            neg_d      = '0;
            rr_d       = '0;
            conflict_d = 1'b0;
            conf_lit_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (in_neg) begin
                    neg_d[vidx] = 1'b1;
                end else begin
                    pos_d[vidx] = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(pop);
            if (gnt_any) begin
                rr_d = (gnt_idx == PW'(NUM_ENGINE - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (do_conf) begin
                conflict_d = 1'b1;
                conf_lit_d = in_lit;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (do_conf) begin
                        state_d = S_CONF;
                    end else if (mem_done) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (do_conf) begin
                        state_d = S_CONF;
                    end
                end
                S_CONF: state_d = S_CONF;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pos_q      <= '0;
            neg_q      <= '0;
            rr_q       <= '0;
            conflict_q <= 1'b0;
            conf_lit_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            rr_q       <= rr_d;
            conflict_q <= conflict_d;
            conf_lit_q <= conf_lit_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (do_push) begin
            fifo_q[wr_ptr_q] <= in_lit;
        end
    end

    assign out_lit      = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    assign q_count      = count_q;
    assign conflict     = conflict_q;
    assign conflict_lit = conf_lit_q;

`ifdef UCARB_STATS_EN
    logic [15:0] st_push_q, st_push_d;
    logic [15:0] st_drop_q, st_drop_d;

    always_comb begin
        st_push_d = st_push_q;
        st_drop_d = st_drop_q;
        if (clear) begin
            st_push_d = '0;
            st_drop_d = '0;
        end else begin
            if (do_push && st_push_q != 16'hFFFF) begin
                st_push_d = st_push_q + 16'd1;
            end
            if (do_drop && st_drop_q != 16'hFFFF) begin
                st_drop_d = st_drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_push_q <= '0;
            st_drop_q <= '0;
        end else begin
            st_push_q <= st_push_d;
            st_drop_q <= st_drop_d;
        end
    end

    assign stat_pushed  = st_push_q;
    assign stat_dropped = st_drop_q;
`else
    assign stat_pushed  = '0;
    assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_uc_arbiter_rr.sv
// Bench for uc_arbiter_rr: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uc_arbiter_rr;

    localparam int NE = 4;
    localparam int LW = 8;
    localparam int NV = 64;
    localparam int QD = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              mem_valid = 1'b0;
    logic [LW-1:0]     mem_lit = '0;
    logic              mem_done = 1'b0;
    logic              mem_ready;
    logic [NE-1:0]     eng_valid = '0;
    logic [NE*LW-1:0]  eng_lit = '0;
    logic [NE-1:0]     eng_ready;
    logic              down_full = 1'b0;
    logic              out_valid;
    logic [LW-1:0]     out_lit;
    logic [4:0]        q_count;
    logic              conflict;
    logic [LW-1:0]     conflict_lit;
    logic [15:0]       stat_pushed;
    logic [15:0]       stat_dropped;

    always #5 clk = ~clk;

    uc_arbiter_rr #(
        .NUM_ENGINE (NE),
        .LIT_W      (LW),
        .NUM_VARS   (NV),
        .Q_DEPTH    (QD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .mem_valid    (mem_valid),
        .mem_lit      (mem_lit),
        .mem_done     (mem_done),
        .mem_ready    (mem_ready),
        .eng_valid    (eng_valid),
        .eng_lit      (eng_lit),
        .eng_ready    (eng_ready),
        .down_full    (down_full),
        .out_valid    (out_valid),
        .out_lit      (out_lit),
        .q_count      (q_count),
        .conflict     (conflict),
        .conflict_lit (conflict_lit),
        .stat_pushed  (stat_pushed),
        .stat_dropped (stat_dropped)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: 0 idle, 1 run, 2 conflict; table holds +1/-1/0 per var.
    int mq[$];
    int tbl[NV];
    int mst;
    int mrr;
    int mclit;
    int mconf;
    int mpush;
    int mdrop;
    int popped[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int slit(input logic [LW-1:0] l);
        return int'($signed(l));
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (tbl[i]) tbl[i] = 0;
        mst   = 0;
        mrr   = 0;
        mclit = 0;
        mconf = 0;
        mpush = 0;
        mdrop = 0;
    endtask

    always @(negedge clk) begin
        int  gr;
        int  full;
        int  mrdy;
        int  ov;
        int  lit;
        int  a;
        int  s;
        int  ch;
        if (!rst_n) model_reset();
        full = (mq.size() == QD) ? 1 : 0;
        mrdy = (mst == 0 && mem_valid && !full && !clear) ? 1 : 0;
        gr = -1;
        if (mst == 1 && !full && !clear) begin
            for (int k = 0; k < NE; k++) begin
                ch = (mrr + k) % NE;
                if (gr < 0 && eng_valid[ch]) gr = ch;
            end
        end
        ov = (mq.size() != 0 && !down_full && mst != 2 && !clear) ? 1 : 0;
        chk("mem_ready", int'(mem_ready), mrdy);
        chk("eng_ready", int'(eng_ready), (gr < 0) ? 0 : (1 << gr));
        chk("out_valid", int'(out_valid), ov);
        if (ov != 0 && out_valid) chk("out_lit", slit(out_lit), mq[0]);
        chk("q_count", int'(q_count), mq.size());
        chk("conflict", int'(conflict), mconf);
        chk("conflict_lit", slit(conflict_lit), mclit);
`ifdef UCARB_STATS_EN
        chk("stat_pushed", int'(stat_pushed), mpush);
        chk("stat_dropped", int'(stat_dropped), mdrop);
`else
        chk("stat_pushed", int'(stat_pushed), 0);
        chk("stat_dropped", int'(stat_dropped), 0);
`endif
        if (out_valid) popped.push_back(slit(out_lit));
        if (rst_n) begin
            if (clear) begin
                model_reset();
            end else begin
                if (ov != 0) void'(mq.pop_front());
                if (mrdy != 0 || gr >= 0) begin
                    lit = (mrdy != 0) ? slit(mem_lit) : slit(eng_lit[gr*LW +: LW]);
                    a = (lit < 0) ? -lit : lit;
                    s = (lit < 0) ? -1 : 1;
                    if (lit == -(1 << (LW - 1)) || a == 0 || a >= NV) begin
                        if (mdrop < 65535) mdrop++;
                    end else if (tbl[a] == s) begin
                        if (mdrop < 65535) mdrop++;
                    end else if (tbl[a] == -s) begin
                        mconf = 1;
                        mclit = lit;
                        mst   = 2;
                    end else begin
                        tbl[a] = s;
                        mq.push_back(lit);
                        if (mpush < 65535) mpush++;
                    end
                end
                if (gr >= 0) mrr = (gr + 1) % NE;
                if (mst == 0 && mem_done) mst = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setl(input int ch, input int v);
        eng_lit[ch*LW +: LW] = LW'(v);
    endtask

    function automatic int rnd_lit();
        int r;
        int m;
        r = int'($urandom_range(0, 15));
        if (r == 0) return int'($signed(LW'($urandom)));
        if (r == 1) return -(1 << (LW - 1));
        m = int'($urandom_range(0, 40));
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    initial begin
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        #2;
        chk("rst_q_count", int'(q_count), 0);
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_mem_ready", int'(mem_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // Memory preload 3,-5,7.
        popped.delete();
        cyc(); mem_valid = 1'b1; mem_lit = LW'(3);
        cyc(); mem_lit = LW'(-5);
        cyc(); mem_lit = LW'(7); mem_done = 1'b1;
        cyc(); mem_valid = 1'b0; mem_done = 1'b0;
        repeat (3) cyc();
        chk("load_npop", popped.size(), 3);
        chk("load_pop0", (popped.size() > 0) ? popped[0] : -999, 3);
        chk("load_pop1", (popped.size() > 1) ? popped[1] : -999, -5);
        chk("load_pop2", (popped.size() > 2) ? popped[2] : -999, 7);
        chk("load_q_count", int'(q_count), 0);

        // All channels busy: grants rotate 0,1,2,3,0.
        for (int c = 0; c < 5; c++) begin
            cyc();
            eng_valid = '1;
            for (int i = 0; i < NE; i++) setl(i, 10 + 4 * c + i);
            #2;
            chk("rr_grant", int'(eng_ready), 1 << (c % NE));
        end
        cyc(); eng_valid = '0;

        // Duplicate from channel 1.
        cyc(); eng_valid = 4'b0010; setl(1, 9);
        cyc();
        cyc(); eng_valid = '0;
        cyc(); #2;
`ifdef UCARB_STATS_EN
        chk("dup_pushed", int'(stat_pushed), 9);
        chk("dup_dropped", int'(stat_dropped), 1);
`else
        chk("dup_pushed", int'(stat_pushed), 0);
        chk("dup_dropped", int'(stat_dropped), 0);
`endif

        // Conflict: mem 4 then channel 2 sends -4.
        cyc(); clear = 1'b1;
        cyc(); clear = 1'b0; mem_valid = 1'b1; mem_lit = LW'(4);
        mem_done = 1'b1; down_full = 1'b1;
        cyc(); mem_valid = 1'b0; mem_done = 1'b0;
        eng_valid = 4'b0100; setl(2, -4);
        #2;
        chk("conf_grant", int'(eng_ready), 4);
        cyc(); eng_valid = '1; down_full = 1'b0;
        for (int i = 0; i < NE; i++) setl(i, 50 + i);
        #2;
        chk("conf_flag", int'(conflict), 1);
        chk("conf_lit", slit(conflict_lit), -4);
        chk("conf_eng_ready", int'(eng_ready), 0);
        chk("conf_out_valid", int'(out_valid), 0);
        chk("conf_q_count", int'(q_count), 1);
        cyc(); #2;
        chk("conf_hold", int'(out_valid), 0);
        cyc(); clear = 1'b1; eng_valid = '0;
        cyc(); clear = 1'b0; #2;
        chk("clr_conflict", int'(conflict), 0);
        chk("clr_q_count", int'(q_count), 0);
        mem_valid = 1'b1; mem_lit = LW'(-4); mem_done = 1'b1; down_full = 1'b1;
        cyc(); mem_valid = 1'b0; mem_done = 1'b0; #2;
        chk("reacc_conflict", int'(conflict), 0);
        chk("reacc_q_count", int'(q_count), 1);

        // Fill the FIFO while downstream is blocked.
        cyc(); clear = 1'b1;
        cyc(); clear = 1'b0; mem_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(); mem_done = 1'b0; eng_valid = 4'b0001; setl(0, k + 1);
        end
        #2;
        chk("full_q_count", int'(q_count), 16);
        chk("full_eng_ready", int'(eng_ready), 0);
        cyc(); down_full = 1'b0; setl(0, 21); #2;
        chk("full_pop", int'(out_valid), 1);
        chk("full_pop_nogrant", int'(eng_ready), 0);
        cyc(); #2;
        chk("resume_grant", int'(eng_ready), 1);
        chk("resume_q_count", int'(q_count), 15);

        // Asynchronous reset in the middle of a run.
        cyc(); eng_valid = '0; rst_n = 1'b0;
        cyc(); rst_n = 1'b1; #2;
        chk("mid_rst_q_count", int'(q_count), 0);
        chk("mid_rst_conflict", int'(conflict), 0);
        mem_valid = 1'b1; mem_lit = LW'(1); mem_done = 1'b1; down_full = 1'b1;
        cyc(); mem_valid = 1'b0; mem_done = 1'b0; #2;
        chk("rst_reacc_q_count", int'(q_count), 1);
        chk("rst_reacc_conflict", int'(conflict), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            cyc();
            clear     = ($urandom_range(0, 39) == 0);
            mem_valid = ($urandom_range(0, 1) == 1);
            mem_lit   = LW'(rnd_lit());
            mem_done  = ($urandom_range(0, 7) == 0);
            eng_valid = NE'($urandom);
            for (int i = 0; i < NE; i++) setl(i, rnd_lit());
            down_full = ($urandom_range(0, 3) < ((c < 750) ? 3 : 1));
        end
        cyc();
        clear = 1'b0; mem_valid = 1'b0; mem_done = 1'b0;
        eng_valid = '0; down_full = 1'b0;
        repeat (3) cyc();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
